// File: rtl/uart_frame_scheduler.sv
// Streams one frame (sync pair, frame-buffer pixels, XOR checksum) into a byte UART.
// Latency: one byte per UART handshake; pixel bytes add a read and a capture cycle.
module uart_frame_scheduler #(
  parameter int         FRAME_W = 64,
  parameter int         FRAME_H = 48,
  parameter int         ADDR_W  = 12,
  parameter logic [7:0] SYNC0   = 8'hAA,
  parameter logic [7:0] SYNC1   = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              active,
  output logic              frame_done,
  output logic              aborted
);

  localparam int N = FRAME_W * FRAME_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, RD, CAP, SEND, WAIT_HI, WAIT_LO, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SYNC0, PH_SYNC1, PH_PIX, PH_CSUM
  } phase_t;

  state_t            state, state_nxt;
  phase_t            phase, phase_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [7:0]        tx_data_nxt;
  logic              abort_q, abort_nxt;
  logic              last_pix, last_pix_nxt;
  logic              aborted_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= PH_SYNC0;
      mem_addr <= '0;
      csum     <= '0;
      tx_data  <= '0;
      abort_q  <= 1'b0;
      last_pix <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      mem_addr <= addr_nxt;
      csum     <= csum_nxt;
      tx_data  <= tx_data_nxt;
      abort_q  <= abort_nxt;
      last_pix <= last_pix_nxt;
      aborted  <= aborted_nxt;
    end
  end

  assign active = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    addr_nxt     = mem_addr;
    csum_nxt     = csum;
    tx_data_nxt  = tx_data;
    abort_nxt    = abort_q | ((state != IDLE) & abort);
    last_pix_nxt = last_pix;
    aborted_nxt  = 1'b0;
    mem_rd_en    = 1'b0;
    tx_send      = 1'b0;
    frame_done   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !tx_busy) begin
          state_nxt    = LOAD;
          phase_nxt    = PH_SYNC0;
          addr_nxt     = '0;
          csum_nxt     = '0;
          abort_nxt    = 1'b0;
          last_pix_nxt = 1'b0;
        end
      end
      LOAD: begin
        case (phase)
          PH_SYNC0: begin tx_data_nxt = SYNC0; state_nxt = SEND; end
          PH_SYNC1: begin tx_data_nxt = SYNC1; state_nxt = SEND; end
          PH_CSUM:  begin tx_data_nxt = csum;  state_nxt = SEND; end
          default:  state_nxt = RD;
        endcase
      end
      RD: begin
        mem_rd_en = 1'b1;
        state_nxt = CAP;
      end
      CAP: begin
        tx_data_nxt = mem_data;
        csum_nxt    = csum ^ mem_data;
        // The last address is held rather than wrapped so the counter never overflows.
        if (mem_addr == LAST_ADDR) last_pix_nxt = 1'b1;
        else                       addr_nxt     = mem_addr + ADDR_W'(1);
        state_nxt = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_send   = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (abort_q || abort) begin
            state_nxt   = IDLE;
            aborted_nxt = 1'b1;
            abort_nxt   = 1'b0;
          end else begin
            case (phase)
              PH_SYNC0: begin phase_nxt = PH_SYNC1; state_nxt = LOAD; end
              PH_SYNC1: begin phase_nxt = PH_PIX;   state_nxt = LOAD; end
              PH_PIX: begin
                if (last_pix) phase_nxt = PH_CSUM;
                state_nxt = LOAD;
              end
              default:  state_nxt = DONE;
            endcase
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Randomised bench for uart_frame_scheduler: byte-level frame model plus directed literal frames.
module tb_uart_frame_scheduler;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int AW = 3;
  localparam int N  = FW * FH;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_busy;
  logic          active, frame_done, aborted;
  logic          uart_busy, hold_busy;

  assign tx_busy = uart_busy | hold_busy;

  uart_frame_scheduler #(
    .FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .SYNC0(8'hAA), .SYNC1(8'h55)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .active(active), .frame_done(frame_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame buffer: one-cycle read latency, junk on idle cycles.
  logic [7:0] mem [N];
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
    else           mem_data <= 8'($urandom);
  end

  // UART: busy rises 1..3 cycles after a send and lasts 1..4 cycles.
  initial begin
    int d, b;
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send) begin
        d = $urandom_range(1, 3);
        b = $urandom_range(1, 4);
        repeat (d) @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (b) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Behavioural model: list of bytes still owed for the current frame.
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] ref_q[$];
  logic       exp_active = 1'b0;
  logic       want_done = 1'b0, want_abort = 1'b0;
  logic       abort_pend = 1'b0, outstanding = 1'b0, seen_hi = 1'b0;
  logic [7:0] last_byte = 8'h00;
  int         exp_addr = 0;
  int         done_cnt = 0, abort_cnt = 0, send_cnt = 0;

  always @(negedge clk) begin : compare
    logic       a, completion, nd, na;
    logic [8:0] eb;
    logic [7:0] x;
    a = exp_active;
    chk("active", 32'(active), 32'(exp_active));
    chk("frame_done", 32'(frame_done), 32'(want_done));
    chk("aborted", 32'(aborted), 32'(want_abort));
    if (frame_done) done_cnt++;
    if (aborted) abort_cnt++;
    if (mem_rd_en) begin
      chk("rd_in_frame", 32'(mem_rd_en), 32'(exp_active));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      exp_addr++;
    end
    if (outstanding) chk("tx_data_hold", 32'(tx_data), 32'(last_byte));
    if (tx_send) begin
      chk("send_while_busy", 32'(tx_busy), 32'(0));
      chk("send_outstanding", 32'(outstanding), 32'(0));
      eb = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
      chk("tx_data", 32'(tx_data), 32'(eb));
      sent_q.push_back(tx_data);
      send_cnt++;
      last_byte = tx_data;
    end

    nd = 1'b0;
    na = 1'b0;
    if (want_done) exp_active = 1'b0;
    if (a && abort) abort_pend = 1'b1;
    completion = outstanding && seen_hi && !tx_busy;
    if (outstanding && tx_busy) seen_hi = 1'b1;
    if (completion) begin
      outstanding = 1'b0;
      if (abort_pend) begin
        na = 1'b1;
        exp_active = 1'b0;
        exp_q.delete();
        abort_pend = 1'b0;
      end else if (exp_q.size() == 0) begin
        nd = 1'b1;
      end
    end
    if (tx_send) begin
      outstanding = 1'b1;
      seen_hi = 1'b0;
    end
    if (!a && start && !tx_busy) begin
      exp_active = 1'b1;
      exp_addr = 0;
      abort_pend = 1'b0;
      exp_q.delete();
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      x = 8'h00;
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(mem[i]);
        x = x ^ mem[i];
      end
      exp_q.push_back(x);
    end
    want_done = nd;
    want_abort = na;
    if (!rst) begin
      exp_active = 1'b0;
      want_done = 1'b0;
      want_abort = 1'b0;
      abort_pend = 1'b0;
      outstanding = 1'b0;
      exp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    sent_q.delete();
    done_cnt = 0;
    abort_cnt = 0;
    send_cnt = 0;
  endtask

  task automatic wait_idle(input string nm);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!active && !tx_busy) break;
      tick();
    end
    chk({nm, "_idle_timeout"}, 32'(active), 32'(0));
    tick();
  endtask

  task automatic wait_sends(input string nm, input int n);
    for (int i = 0; i < 400; i++) begin
      if (send_cnt >= n) break;
      tick();
    end
    chk({nm, "_send_timeout"}, 32'(send_cnt >= n), 32'(1));
  endtask

  task automatic chk_ref(input string nm);
    chk({nm, "_len"}, 32'(sent_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < sent_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(sent_q[i]), 32'(ref_q[i]));
  endtask

  task automatic ref_count_frame();
    ref_q.delete();
    ref_q.push_back(8'hAA);
    ref_q.push_back(8'h55);
    for (int i = 1; i <= 8; i++) ref_q.push_back(8'(i));
    ref_q.push_back(8'h08);
  endtask

  task automatic run_frame(input string nm);
    clear_log();
    pulse_start();
    wait_idle(nm);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    hold_busy = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'(i + 1);
    tick();
    tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
    chk("rst_tx_send", 32'(tx_send), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_active", 32'(active), 32'(0));
    chk("rst_done_abort", 32'({frame_done, aborted}), 32'(0));
    rst = 1'b1;
    tick();

    // Counting frame, with starts pulsed mid-frame that must be ignored.
    clear_log();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      repeat (7) tick();
      pulse_start();
    end
    wait_idle("count");
    ref_count_frame();
    chk_ref("count");
    chk("count_done_cnt", 32'(done_cnt), 32'(1));
    chk("count_send_cnt", 32'(send_cnt), 32'(11));
    chk("count_abort_cnt", 32'(abort_cnt), 32'(0));

    // Start ignored while the transmitter reports busy.
    hold_busy = 1'b1;
    tick();
    pulse_start();
    repeat (3) tick();
    chk("busy_start_ignored", 32'(active), 32'(0));
    hold_busy = 1'b0;
    tick();
    run_frame("after_busy");
    chk_ref("after_busy");

    // Abort during the third pixel byte.
    clear_log();
    pulse_start();
    wait_sends("abort", 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle("abort");
    ref_q.delete();
    ref_q.push_back(8'hAA);
    ref_q.push_back(8'h55);
    ref_q.push_back(8'h01);
    ref_q.push_back(8'h02);
    ref_q.push_back(8'h03);
    chk_ref("abort");
    chk("abort_abort_cnt", 32'(abort_cnt), 32'(1));
    chk("abort_done_cnt", 32'(done_cnt), 32'(0));

    // Reset while pixel 2 is on the line, then a clean frame.
    clear_log();
    pulse_start();
    wait_sends("reset", 4);
    rst = 1'b0;
    tick();
    chk("midrst_mem_addr", 32'(mem_addr), 32'(0));
    chk("midrst_rd_send", 32'({mem_rd_en, tx_send}), 32'(0));
    chk("midrst_tx_data", 32'(tx_data), 32'(0));
    chk("midrst_flags", 32'({active, frame_done, aborted}), 32'(0));
    rst = 1'b1;
    wait_idle("midrst");
    run_frame("post_rst");
    ref_count_frame();
    chk_ref("post_rst");
    chk("post_rst_done_cnt", 32'(done_cnt), 32'(1));

    // Start and abort together in IDLE: start wins.
    clear_log();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    wait_idle("start_abort");
    chk("start_abort_done_cnt", 32'(done_cnt), 32'(1));
    chk("start_abort_send_cnt", 32'(send_cnt), 32'(11));

    // All-ones frame buffer cancels to a zero checksum.
    for (int i = 0; i < N; i++) mem[i] = 8'hFF;
    run_frame("ones");
    ref_q.delete();
    ref_q.push_back(8'hAA);
    ref_q.push_back(8'h55);
    for (int i = 0; i < N; i++) ref_q.push_back(8'hFF);
    ref_q.push_back(8'h00);
    chk_ref("ones");

    // Random frames with sporadic starts, aborts and resets.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      clear_log();
      pulse_start();
      for (int c = 0; c < 300; c++) begin
        if (!active) break;
        abort = ($urandom_range(0, 99) < 2);
        start = ($urandom_range(0, 99) < 3);
        rst   = !($urandom_range(0, 999) < 3);
        tick();
        rst = 1'b1;
      end
      wait_idle("rand");
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_frame_scheduler.md
UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_W, default 64, pixels per row.
REQ-002 SHALL have parameter FRAME_H, default 48, rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 12, frame-buffer address width; FRAME_W*FRAME_H <= 2^ADDR_W.
REQ-004 SHALL have parameter SYNC0, default 8'hAA, first header byte.
REQ-005 SHALL have parameter SYNC1, default 8'h55, second header byte.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle request to transmit one frame.
REQ-009 SHALL have port abort  input  1  stop after the byte currently on the line.
REQ-010 SHALL have port mem_rd_en  output  1  frame-buffer read strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  frame-buffer read address.
REQ-012 SHALL have port mem_data  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-014 SHALL have port tx_send  output  1  one-cycle send pulse to the UART transmitter.
REQ-015 SHALL have port tx_busy  input  1  UART transmitter busy flag.
REQ-016 SHALL have port active  output  1  high from accepted start until return to IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after checksum byte completes.
REQ-018 SHALL have port aborted  output  1  one-cycle pulse when an abort ends a frame.

Function
REQ-019 SHALL transmit per frame: SYNC0, SYNC1, N=FRAME_W*FRAME_H pixel bytes at addresses 0..N-1 ascending, then checksum byte.
REQ-020 Checksum SHALL be the 8-bit XOR of all N pixel bytes; sync bytes excluded; cleared on each accepted start.
REQ-021 States: IDLE, LOAD (sync/checksum select), RD (mem_rd_en=1, one cycle), CAP (latch mem_data), SEND, WAIT_HI, WAIT_LO, DONE.
REQ-022 IDLE: start accepted only when tx_busy=0; start while tx_busy=1 or while active=1 SHALL be ignored.
REQ-023 SEND: tx_send=1 for exactly one cycle, only when tx_busy=0; tx_data held stable from SEND until WAIT_LO exits.
REQ-024 WAIT_HI: wait for tx_busy=1; WAIT_LO: wait for tx_busy=0; then advance to next byte.
REQ-025 Pixel bytes: RD then CAP then SEND; mem_addr increments by 1 after each CAP; mem_rd_en never high outside RD.
REQ-026 Last pixel (addr N-1) SHALL be followed by the checksum byte with no memory read.
REQ-027 After checksum WAIT_LO: DONE for one cycle (frame_done=1), then IDLE with active=0.
REQ-028 abort sampled in any non-IDLE state SHALL be latched; at next WAIT_LO exit go IDLE, pulse aborted, no frame_done, no checksum.
REQ-029 abort and start in same IDLE cycle: start wins, abort ignored.
REQ-030 Address counter SHALL not wrap within a frame; reset to 0 on each accepted start.
REQ-031 tx_send SHALL never be asserted twice within one byte; at most one outstanding byte.

Reset
REQ-032 rst=0 at any clock edge SHALL force IDLE, mem_addr=0, mem_rd_en=0, tx_send=0, tx_data=0, active=0, frame_done=0, aborted=0, checksum=0, abort latch cleared.
REQ-033 Reset mid-frame SHALL discard the frame; next start restarts at SYNC0, address 0.

Verification
REQ-034 FRAME_W=4, FRAME_H=2, memory = 01..08, UART 9600 baud model; start -> bytes AA,55,01,02,03,04,05,06,07,08,08 in order, frame_done once.
REQ-035 start pulsed while active -> ignored; exactly 11 tx_send pulses for the frame.
REQ-036 abort asserted during 3rd pixel byte -> 3rd pixel completes, aborted pulses, no checksum, active=0, mem_rd_en stays 0.
REQ-037 rst=0 during pixel 2 -> all outputs at reset values next cycle; subsequent start yields full correct frame from AA.
REQ-038 start with tx_busy held 1 -> ignored; start after tx_busy=0 -> accepted, tx_send follows SYNC0.
REQ-039 Memory all FF, 4x2 frame -> checksum byte 00; each mem_rd_en followed by CAP capture of data 1 cycle later.
